m_bcd_counter_n: RTL

M_BCD_COUNTER_N -- requirements
Module: m_bcd_counter_n

---
 rtl/m_bcd_pkg.sv | 42 ++++
 rtl/m_bcd_digit.sv | 47 ++++
 rtl/m_bcd_counter_n.sv | 118 +++++++++++
 3 files changed

// File: rtl/m_bcd_pkg.sv
// Shared BCD constants and single-decade step functions for the BCD counter.
// A step function returns the next nibble plus a carry (up) or borrow (down) flag.
package m_bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'h9;
  localparam logic [3:0] BCD_MIN = 4'h0;

  typedef struct packed {
    logic       cy;
    logic [3:0] nib;
  } bcd_step_t;

  function automatic logic bcd_is_digit(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

  // A non-BCD nibble steps to zero and never generates a carry.
  function automatic bcd_step_t bcd_inc(input logic [3:0] d);
    bcd_step_t r;
    r.cy  = 1'b0;
    r.nib = d + 4'd1;
    if (d >= BCD_MAX) begin
      r.cy  = (d == BCD_MAX);
      r.nib = BCD_MIN;
    end
    return r;
  endfunction

  function automatic bcd_step_t bcd_dec(input logic [3:0] d);
    bcd_step_t r;
    r.cy  = 1'b0;
    r.nib = d - 4'd1;
    if (d == BCD_MIN) begin
      r.cy  = 1'b1;
      r.nib = BCD_MAX;
    end else if (d > BCD_MAX) begin
      r.nib = BCD_MIN;
    end
    return r;
  endfunction

endpackage

// File: rtl/m_bcd_digit.sv
// One BCD decade: nibble register with clear/load/count and a ripple
// carry/borrow chain (ci in from the lower decade, co out to the next).
module m_bcd_digit
  import m_bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] ld_nib,
  input  logic       cnt,
  input  logic       ci,
  input  logic       up,
  output logic [3:0] q,
  output logic       co
);

  logic [3:0] nib_q, nib_d;
  bcd_step_t  stp;

  always_comb begin
    stp   = up ? bcd_inc(nib_q) : bcd_dec(nib_q);
    co    = ci & stp.cy;
    nib_d = nib_q;
    if (clr) begin
      nib_d = BCD_MIN;
    end else if (ld) begin
      nib_d = ld_nib;
    end else if (cnt && (nib_q > BCD_MAX)) begin
      // Any enabled count scrubs a corrupted decade, even without a carry in.
      nib_d = BCD_MIN;
    end else if (ci) begin
      nib_d = stp.nib;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nib_q <= BCD_MIN;
    end else begin
      nib_q <= nib_d;
    end
  end

  assign q = nib_q;

endmodule

// File: rtl/m_bcd_counter_n.sv
// N-decade up/down BCD counter with load/clear, wrap or saturate at the
// terminal count, and a prescaled one-hot scan for a multiplexed display.
module m_bcd_counter_n
  import m_bcd_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int WRAP     = 1,
  parameter int SCAN_DIV = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  en,
  input  logic                  up,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  tc,
  output logic                  ovf,
  output logic                  load_err,
  output logic [DIGITS-1:0]     scan_sel,
  output logic [3:0]            scan_bcd
);

  localparam int                PW         = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]     PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [DIGITS-1:0] SEL_RST    = DIGITS'(1);

  logic [DIGITS:0]   carry;
  logic              all_max, all_min, load_ok;
  logic              cnt_req, cnt, ld;
  logic              ovf_q, ovf_d;
  logic              lerr_q, lerr_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [DIGITS-1:0] sel_q, sel_d;

  always_comb begin
    all_max = 1'b1;
    all_min = 1'b1;
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      all_max = all_max & (bcd_out[4*i +: 4] == BCD_MAX);
      all_min = all_min & (bcd_out[4*i +: 4] == BCD_MIN);
      load_ok = load_ok & bcd_is_digit(load_val[4*i +: 4]);
    end
  end

  assign tc      = up ? all_max : all_min;
  assign cnt_req = en & ~clr & ~load;
  // Saturate mode freezes the chain at the terminal; wrap lets it roll over.
  assign cnt     = cnt_req & ~(tc & (WRAP == 0));
  assign ld      = ~clr & load & load_ok;
  assign carry[0] = cnt;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    m_bcd_digit u_digit (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .ld     (ld),
      .ld_nib (load_val[4*g +: 4]),
      .cnt    (cnt),
      .ci     (carry[g]),
      .up     (up),
      .q      (bcd_out[4*g +: 4]),
      .co     (carry[g+1])
    );
  end

  always_comb begin
    // In wrap mode the carry leaving the top decade is exactly "counted at tc".
    if (WRAP != 0) begin
      ovf_d = carry[DIGITS];
    end else begin
      ovf_d = cnt_req & tc;
    end
    lerr_d = ~clr & load & ~load_ok;
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    sel_d   = sel_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      for (int i = 0; i < DIGITS; i++) begin
        sel_d[i] = sel_q[(i + DIGITS - 1) % DIGITS];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q   <= 1'b0;
      lerr_q  <= 1'b0;
      presc_q <= '0;
      sel_q   <= SEL_RST;
    end else begin
      ovf_q   <= ovf_d;
      lerr_q  <= lerr_d;
      presc_q <= presc_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    scan_bcd = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel_q[i]) begin
        scan_bcd = scan_bcd | bcd_out[4*i +: 4];
      end
    end
  end

  assign ovf      = ovf_q;
  assign load_err = lerr_q;
  assign scan_sel = sel_q;

endmodule
